// File: rtl/lfsr_keystream_sched.sv
// lfsr_keystream_sched: time-shares one external 8-bit keystream LFSR between
// NUM_REQ channels. Each channel keeps its own saved LFSR state (context).
// A grant restores that context into the LFSR, streams up to BURST_MAX bytes,
// and then saves the next unused state back.
// Optional build macro KS_SCHED_TIMEOUT_EN: a stalled owner is released after
// STALL_MAX consecutive cycles without a transfer.
module lfsr_keystream_sched #(
   parameter int unsigned NUM_REQ   = 2,
   parameter int unsigned BURST_MAX = 16,
   parameter logic [7:0]  SEED      = 8'd32,
   parameter int unsigned STALL_MAX = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ-1:0]     ks_ready,
   output logic [NUM_REQ-1:0]     ks_valid,
   output logic [7:0]             ks_data,
   output logic [NUM_REQ-1:0]     gnt,
   input  logic [NUM_REQ-1:0]     rekey,
   input  logic [8*NUM_REQ-1:0]   rekey_key,
   output logic                   lfsr_enable,
   output logic                   lfsr_pause,
   output logic                   lfsr_load,
   output logic [7:0]             lfsr_ldata,
   input  logic [7:0]             lfsr_data
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned SUM_W = IDX_W + 1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, SAVE} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] sel, rr_ptr, pick;
   logic [SUM_W-1:0] sum;
   logic             pick_ok;
   logic [7:0]       ctx [NUM_REQ];
   logic [7:0]       count;
   logic             pend_vld;
   logic [7:0]       pend_key;
   logic             xfer, last_byte, stall_exit;

   // An all-zero context would lock the LFSR, so it is replaced by SEED.
   function automatic logic [7:0] key_or_seed(input logic [7:0] k);
      return (k == 8'h00) ? SEED : k;
   endfunction

   assign xfer      = (state == RUN) && req[sel] && ks_ready[sel];
   assign last_byte = (count == 8'(BURST_MAX - 1));
   assign ks_data   = lfsr_data;

`ifdef KS_SCHED_TIMEOUT_EN
   localparam int unsigned STALL_W = $clog2(STALL_MAX) + 1;

   logic [STALL_W-1:0] stall_cnt;
   logic               stalling;

   assign stalling   = (state == RUN) && req[sel] && !ks_ready[sel];
   assign stall_exit = stalling && (stall_cnt == STALL_W'(STALL_MAX - 1));

   // Consecutive stall cycles of the current owner; any transfer restarts it.
   always_ff @(posedge clk) begin
      if (reset || state != RUN || xfer)
         stall_cnt <= '0;
      else if (stalling)
         stall_cnt <= stall_cnt + STALL_W'(1);
   end
`else
   assign stall_exit = 1'b0;

   // No stall limit in this build; a stalled owner keeps the LFSR.
   if (STALL_MAX == 0) begin : g_stall_limit_unused
   end
`endif

   // Round-robin pick: first requester at or after rr_ptr, wrapping.
   always_comb begin
      pick    = rr_ptr;
      pick_ok = 1'b0;
      sum     = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr} + SUM_W'(k);
         if (sum >= SUM_W'(NUM_REQ))
            sum = sum - SUM_W'(NUM_REQ);
         if (!pick_ok && req[sum[IDX_W-1:0]]) begin
            pick    = sum[IDX_W-1:0];
            pick_ok = 1'b1;
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state: one-cycle LOAD and SAVE around a RUN burst.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_ok) state_nxt = LOAD;
         LOAD:    state_nxt = RUN;
         RUN:     if (!req[sel] || (xfer && last_byte) || stall_exit) state_nxt = SAVE;
         SAVE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: grant, byte valid and LFSR controls decoded from state.
   always_comb begin
      gnt        = '0;
      ks_valid   = '0;
      lfsr_load  = 1'b0;
      lfsr_ldata = '0;
      lfsr_pause = 1'b1;
      case (state)
         LOAD: begin
            gnt[sel]   = 1'b1;
            lfsr_load  = 1'b1;
            lfsr_ldata = ctx[sel];
         end
         RUN: begin
            gnt[sel]      = 1'b1;
            ks_valid[sel] = req[sel];
            lfsr_pause    = !xfer;
         end
         SAVE:    gnt[sel] = 1'b1;
         default: ;
      endcase
   end

   // Context store, owner select, byte count and pending rekey.
   // A rekey aimed at the channel in LOAD/RUN is parked and lands in SAVE,
   // overriding the captured LFSR state; a rekey during SAVE itself is
   // written directly and therefore also wins over the capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_enable <= 1'b0;
         sel         <= '0;
         rr_ptr      <= '0;
         count       <= '0;
         pend_vld    <= 1'b0;
         pend_key    <= '0;
         for (int unsigned i = 0; i < NUM_REQ; i++)
            ctx[i] <= SEED;
      end else begin
         lfsr_enable <= 1'b1;
         if (state == IDLE && pick_ok)
            sel <= pick;
         if (state == LOAD)
            count <= '0;
         else if (xfer)
            count <= count + 8'd1;
         if (state == SAVE) begin
            ctx[sel] <= lfsr_data;
            if (pend_vld)
               ctx[sel] <= pend_key;
            pend_vld <= 1'b0;
            rr_ptr   <= (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + IDX_W'(1);
         end
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rekey[i]) begin
               if ((state == LOAD || state == RUN) && sel == IDX_W'(i)) begin
                  pend_vld <= 1'b1;
                  pend_key <= key_or_seed(rekey_key[8*i +: 8]);
               end else begin
                  ctx[i] <= key_or_seed(rekey_key[8*i +: 8]);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_lfsr_keystream_sched.sv
// Testbench for lfsr_keystream_sched: models the external LFSR, runs a table
// of bursts, hand-written corner sequences and a randomized run checked
// against per-channel keystream contexts.
module tb_lfsr_keystream_sched;

   localparam logic [7:0] SEED = 8'h20;
   localparam int         BMAX = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req, ks_ready, ks_valid, gnt, rekey;
   logic [7:0]  ks_data, lfsr_ldata, lfsr_q;
   logic [15:0] rekey_key;
   logic        lfsr_enable, lfsr_pause, lfsr_load;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lfsr_keystream_sched #(
      .NUM_REQ   (2),
      .BURST_MAX (BMAX),
      .SEED      (SEED),
      .STALL_MAX (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .ks_ready    (ks_ready),
      .ks_valid    (ks_valid),
      .ks_data     (ks_data),
      .gnt         (gnt),
      .rekey       (rekey),
      .rekey_key   (rekey_key),
      .lfsr_enable (lfsr_enable),
      .lfsr_pause  (lfsr_pause),
      .lfsr_load   (lfsr_load),
      .lfsr_ldata  (lfsr_ldata),
      .lfsr_data   (lfsr_q)
   );

   function automatic logic [7:0] step(input logic [7:0] s);
      return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00);
   endfunction

   function automatic logic [7:0] adv(input logic [7:0] s, input int n);
      logic [7:0] r;
      r = s;
      for (int i = 0; i < n; i++) r = step(r);
      return r;
   endfunction

   // External keystream LFSR: enable=0 seeds, load beats advance, pause holds.
   always @(posedge clk) begin
      if (!lfsr_enable)    lfsr_q <= SEED;
      else if (lfsr_load)  lfsr_q <= lfsr_ldata;
      else if (!lfsr_pause) lfsr_q <= step(lfsr_q);
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // One burst from IDLE: req=mask, checks grant, load value, latency, every
   // byte, saved state and length. Optionally toggles ready and pulses rekey
   // on the owner at RUN cycle rk_iter.
   task automatic do_burst(input logic [1:0] mask, input int owner, input logic [7:0] first,
                           input int len, input bit toggle, input int rk_iter,
                           input logic [7:0] rk_key, input string tag);
      logic [7:0] exp;
      logic [1:0] oh;
      int cnt, first_at;
      bit done;
      oh = 2'b01 << owner;
      exp = first; cnt = 0; first_at = -1; done = 1'b0;
      @(posedge clk); #1; req = mask; ks_ready = 2'b11;
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, " load"}, lfsr_load, 1);
      chk({tag, " ldata"}, lfsr_ldata, first);
      chk({tag, " gnt"}, gnt, oh);
      for (int j = 0; j < 40 && !done; j++) begin
         @(posedge clk); #1;
         ks_ready = (toggle && (j % 2 == 1)) ? 2'b00 : 2'b11;
         if (j == rk_iter) begin
            rekey = oh; rekey_key = {rk_key, rk_key};
         end else begin
            rekey = 2'b00;
         end
         @(negedge clk);
         if (gnt == 2'b00) begin
            req = 2'b00; done = 1'b1;
         end else if (ks_valid != 2'b00) begin
            if (first_at < 0) first_at = j;
            chk({tag, " valid"}, ks_valid, oh);
            chk({tag, " byte"}, ks_data, exp);
            if (ks_ready[owner]) begin
               exp = step(exp); cnt++;
            end
         end else if (cnt > 0) begin
            chk({tag, " saved"}, ks_data, exp);
         end
      end
      rekey = 2'b00;
      chk({tag, " ended"}, done, 1);
      chk({tag, " count"}, cnt, len);
      chk({tag, " latency"}, first_at, 0);
   endtask

   typedef struct {
      logic [1:0] mask;
      int         owner;
      logic [7:0] first;
      int         len;
      bit         toggle;
   } vec_t;

   vec_t       tbl [6];
   logic [7:0] exp, k;
   logic [7:0] ctx_m [2];
   logic [1:0] prev_gnt;
   int         cnt, idle_n, held, blen;
   bit         sw;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{2'b01, 0, 8'h20, BMAX, 1'b0};
      tbl[1] = '{2'b01, 0, 8'h3A, BMAX, 1'b0};
      tbl[2] = '{2'b11, 1, 8'h20, BMAX, 1'b0};
      tbl[3] = '{2'b11, 0, 8'h87, BMAX, 1'b0};
      tbl[4] = '{2'b11, 1, 8'h3A, BMAX, 1'b0};
      tbl[5] = '{2'b01, 0, 8'h98, BMAX, 1'b1};

      req = '0; ks_ready = '0; rekey = '0; rekey_key = '0; reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst gnt", gnt, 0);
      chk("rst valid", ks_valid, 0);
      chk("rst load", lfsr_load, 0);
      chk("rst pause", lfsr_pause, 1);
      chk("rst enable", lfsr_enable, 0);
      chk("rst ldata", lfsr_ldata, 0);
      @(posedge clk); #1; reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("enable after rst", lfsr_enable, 1);

      foreach (tbl[i])
         do_burst(tbl[i].mask, tbl[i].owner, tbl[i].first, tbl[i].len, tbl[i].toggle, -1, 8'h00, "tbl");

      // Rekey with 0x00 while idle falls back to SEED.
      @(posedge clk); #1; rekey = 2'b10; rekey_key = 16'h00AA;
      @(posedge clk); #1; rekey = 2'b00;
      do_burst(2'b10, 1, 8'h20, BMAX, 1'b0, -1, 8'h00, "rekey0");

      // Rekey of the owner mid-burst: current burst untouched, next starts at key.
      do_burst(2'b01, 0, 8'h75, BMAX, 1'b0, 1, 8'h55, "rekey mid");
      do_burst(2'b01, 0, 8'h55, BMAX, 1'b0, -1, 8'h00, "rekey next");

      // Single requester held: re-granted with a one-cycle IDLE gap, stream continuous.
      exp = adv(8'h55, BMAX); cnt = 0; idle_n = 0;
      @(posedge clk); #1; req = 2'b01; ks_ready = 2'b11;
      @(negedge clk);
      for (int c = 1; c <= 13; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (gnt == 2'b00) idle_n++;
         if (ks_valid[0]) begin
            chk("regrant byte", ks_data, exp);
            exp = step(exp); cnt++;
         end
      end
      req = 2'b00;
      chk("regrant xfers", cnt, 2 * BMAX);
      chk("regrant idle gap", idle_n, 1);

      // req dropped during LOAD: empty burst, context unchanged.
      @(posedge clk); #1; req = 2'b10;
      @(posedge clk); #1; req = 2'b00;
      @(negedge clk); chk("drop load gnt", gnt, 2'b10);
      @(posedge clk); #1; @(negedge clk);
      chk("drop run valid", ks_valid, 0);
      chk("drop run gnt", gnt, 2'b10);
      @(posedge clk); #1; @(negedge clk); chk("drop save gnt", gnt, 2'b10);
      @(posedge clk); #1; @(negedge clk); chk("drop idle gnt", gnt, 2'b00);
      do_burst(2'b10, 1, 8'h3A, BMAX, 1'b0, -1, 8'h00, "drop ctx");

      // Reset mid-RUN.
      @(posedge clk); #1; req = 2'b10; ks_ready = 2'b11;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk); chk("mid run valid", ks_valid, 2'b10);
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid rst gnt", gnt, 0);
      chk("mid rst valid", ks_valid, 0);
      chk("mid rst enable", lfsr_enable, 0);
      reset = 1'b0; req = 2'b00;
      do_burst(2'b01, 0, SEED, BMAX, 1'b0, -1, 8'h00, "post rst ch0");
      do_burst(2'b10, 1, SEED, BMAX, 1'b0, -1, 8'h00, "post rst ch1");

`ifdef KS_SCHED_TIMEOUT_EN
      // Stalled owner released after 8 stall cycles; other requester next.
      cnt = 0; sw = 1'b0;
      @(posedge clk); #1; req = 2'b11; ks_ready = 2'b00;
      for (int c = 0; c < 40 && !sw; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (ks_valid[0]) begin
            cnt++;
            chk("stall hold", ks_data, 8'h3A);
         end
         if (gnt == 2'b10) sw = 1'b1;
      end
      chk("stall switched", sw, 1);
      chk("stall cycles", cnt, 8);
`else
      // Without the timeout a stalled owner keeps the grant.
      held = 0;
      @(posedge clk); #1; req = 2'b11; ks_ready = 2'b00;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (gnt == 2'b01 && ks_valid == 2'b01) held++;
      end
      chk("stall held", held, 99);
`endif
      req = 2'b00; sw = 1'b0;
      for (int c = 0; c < 40 && !sw; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (gnt == 2'b00) sw = 1'b1;
      end
      chk("stall release", sw, 1);
      do_burst(2'b01, 0, 8'h3A, BMAX, 1'b0, -1, 8'h00, "stall ctx");

      // Randomized traffic against per-channel keystream contexts.
      @(posedge clk); #1; reset = 1'b1; req = '0; ks_ready = '0; rekey = '0;
      repeat (2) @(posedge clk);
      #1; reset = 1'b0;
      ctx_m[0] = SEED; ctx_m[1] = SEED; prev_gnt = 2'b00; blen = 0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         rekey = 2'b00;
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
            ks_ready[i] = ($urandom_range(0, 3) != 0);
            if (!gnt[i] && $urandom_range(0, 19) == 0) begin
               k = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
               rekey[i] = 1'b1;
               rekey_key[8*i +: 8] = k;
               ctx_m[i] = (k == 8'h00) ? SEED : k;
            end
         end
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (ks_valid[i]) begin
               chk("rnd valid owner", gnt[i], 1);
               if (ks_ready[i]) begin
                  chk("rnd byte", ks_data, ctx_m[i]);
                  ctx_m[i] = step(ctx_m[i]);
                  blen++;
               end
            end
         end
         if (gnt == 2'b00 && prev_gnt != 2'b00) begin
            chk("rnd burst len", blen <= BMAX, 1);
            blen = 0;
         end
         prev_gnt = gnt;
      end
      rekey = 2'b00; req = 2'b00;
      repeat (4) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
